nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-nibble add/subtract engine that drives the existing 4-bit ripple adder (adder4bit) one nibble per clock.
- Latches wide operands and feeds adder4bit its in1/in2/cin.
- Consumes its out/carry/overflow and assembles a NIBBLES*4-bit result with final carry and signed overflow.
- Sits between the operand source and the result/status consumer; start/busy/done handshake.

Parameters:
- NIBBLES, 4: number of 4-bit slices; operand/result width W = 4*NIBBLES (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; latched with the operands.
- a  input  W  operand 1; latched on accepted start.
- b  input  W  operand 2; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- sum  output  W  result; holds until the next accepted start completes a nibble.
- carry  output  1  final carry out (for sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow of the full W-bit operation.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; busy=0, done=0, sum=0, carry=0, overflow=0; index, latched operands and carry register cleared. Takes priority over everything, including mid-RUN (the operation is abandoned, no done).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> latch a, b, sub.
  - carry register = sub; index = 0.
  - Go to RUN.
  - start=0 -> stay.
- RUN (busy=1):
  - adder4bit inputs: in1 = a_lat[4i+3:4i]; in2 = b_lat nibble XOR {4{sub_lat}}; cin = carry register.
  - Each edge: sum[4i+3:4i] <= out; carry register <= carry; index++.
  - When i = NIBBLES-1: also carry <= adder carry, overflow <= adder overflow; go to DONE.
  - start ignored in RUN.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 -> accept as in IDLE and go directly to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; nibbles processed at E1..EN; done high in the cycle after EN. Throughput is one operation per NIBBLES+1 cycles.
- Result outputs:
  - sum nibbles update progressively during RUN; only valid when done=1.
  - carry/overflow update only at the final nibble.
  - All outputs hold their values in IDLE.
- Operand changes on a/b/sub after acceptance have no effect.
- Arithmetic is modulo 2^W.
  - Subtraction is a + ~b + 1.
  - overflow = carry-into-MSB XOR carry-out-of-MSB, taken from the last adder4bit slice.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DONE, 2 bits); default NIBBLES.
- One sub-module instance: adder4bit (existing, unmodified), used as the single shared slice.
- Index counter width = clog2(NIBBLES), min 1.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x4321, sub=0 -> done exactly 5 cycles after the start edge; sum=0x5555, carry=0, overflow=0; busy high 4 cycles.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry=1, overflow=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, carry=0, overflow=1.
- Subtraction cases:
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry=0, overflow=0.
  - Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry=1, overflow=1.
- Start held high throughout, with a/b changed during RUN -> first result unaffected. A second operation is accepted in the DONE cycle; its done comes 5 cycles later.
- rst_n=0 for one edge in the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, carry=0, overflow=0, and no done pulse follows.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared state encoding and default sizing for nibble_serial_adder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

  localparam int NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adder4bit.sv
// ============================================================================
// Module      : adder4bit
// Description : 4-bit ripple-carry adder with carry out and signed overflow.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder4bit (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin,
  output logic [3:0] out,
  output logic       carry,
  output logic       overflow
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    out    = '0;
    w_c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      out[i]   = in1[i] ^ in2[i] ^ w_c[i];
      w_c[i+1] = (in1[i] & in2[i]) | (in1[i] & w_c[i]) | (in2[i] & w_c[i]);
    end
  end

  assign carry    = w_c[4];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign overflow = w_c[3] ^ w_c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module      : nibble_serial_adder
// Description : Wide add/subtract computed one nibble per clock on a shared adder4bit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry,
  output logic                 overflow
);

  localparam int             W    = 4 * NIBBLES;
  localparam int             IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0]  LAST = IW'(NIBBLES - 1);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_cy;

  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [3:0]      w_in1;
  logic [3:0]      w_in2;
  logic [3:0]      w_out;
  logic            w_cy;
  logic            w_ov;
  logic            w_last;
  logic [W-1:0]    w_sum_next;

  // Bring the active nibble down to bit 0 instead of using a variable part-select.
  assign w_a_sh = r_a >> {r_idx, 2'b00};
  assign w_b_sh = r_b >> {r_idx, 2'b00};
  assign w_in1  = w_a_sh[3:0];
  assign w_in2  = w_b_sh[3:0] ^ {4{r_sub}};
  assign w_last = (r_idx == LAST);

  adder4bit u_slice (
    .in1      (w_in1),
    .in2      (w_in2),
    .cin      (r_cy),
    .out      (w_out),
    .carry    (w_cy),
    .overflow (w_ov)
  );

  always_comb begin
    w_sum_next = sum;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IW'(k)) begin
        w_sum_next[4*k +: 4] = w_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_cy     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_cy    <= sub;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum   <= w_sum_next;
          r_cy  <= w_cy;
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            carry    <= w_cy;
            overflow <= w_ov;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_idx    <= '0;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Directed self-checking bench for nibble_serial_adder (NIBBLES=4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({busy, done, carry, overflow} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/carry/ovf = %b, required 0000", {busy, done, carry, overflow});
    end
    n_checks++;
    if (sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_sum: got %h, required 0000", sum);
    end
  endtask

  task automatic test_arith();
    logic [15:0] va[5]  = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] vb[5]  = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        vs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es[5]  = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int v = 0; v < 5; v++) begin
      int cnt;
      int busy_cnt;
      bit got;
      a = va[v]; b = vb[v]; sub = vs[v]; start = 1'b1;
      step();
      start = 1'b0;
      // Scramble operands after acceptance; the result must not change.
      a = ~va[v]; b = 16'hA5A5; sub = ~vs[v];
      busy_cnt = busy ? 1 : 0;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 12) begin
        step();
        cnt++;
        if (done) got = 1'b1;
        else if (busy) busy_cnt++;
      end
      // done visible after the 4th edge past E0, i.e. sampled at E0+5.
      n_checks++;
      if (!got || cnt != 4) begin
        n_fail++;
        $display("FAIL arith%0d_latency: done after %0d edges (seen=%0b), required 4", v, cnt, got);
      end
      n_checks++;
      if (busy_cnt != 4) begin
        n_fail++;
        $display("FAIL arith%0d_busy: busy high %0d cycles, required 4", v, busy_cnt);
      end
      n_checks++;
      if (sum !== es[v]) begin
        n_fail++;
        $display("FAIL arith%0d_sum: got %h, required %h", v, sum, es[v]);
      end
      n_checks++;
      if (carry !== ec[v] || overflow !== eo[v]) begin
        n_fail++;
        $display("FAIL arith%0d_flags: carry=%b ovf=%b, required carry=%b ovf=%b", v, carry, overflow, ec[v], eo[v]);
      end
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== es[v] || carry !== ec[v] || overflow !== eo[v]) begin
        n_fail++;
        $display("FAIL arith%0d_idle_hold: done=%b busy=%b sum=%h carry=%b ovf=%b, required 0 0 %h %b %b",
                 v, done, busy, sum, carry, overflow, es[v], ec[v], eo[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bit got;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    step();
    a = 16'h0F0F; b = 16'h0101;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 12) begin
      step();
      cnt++;
      if (done) got = 1'b1;
    end
    n_checks++;
    if (!got || cnt != 4) begin
      n_fail++;
      $display("FAIL b2b_first_latency: done after %0d edges (seen=%0b), required 4", cnt, got);
    end
    n_checks++;
    if (sum !== 16'h3333) begin
      n_fail++;
      $display("FAIL b2b_first_sum: got %h, required 3333", sum);
    end
    // Edge E5: start still high in the DONE cycle, second op accepted.
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    cnt = 0; got = 1'b0;
    while (!got && cnt < 12) begin
      step();
      cnt++;
      if (done) got = 1'b1;
    end
    n_checks++;
    if (!got || cnt != 4) begin
      n_fail++;
      $display("FAIL b2b_second_latency: done after %0d edges (seen=%0b), required 4", cnt, got);
    end
    n_checks++;
    if (sum !== 16'h1010 || carry !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_result: sum=%h carry=%b ovf=%b, required 1010 0 0", sum, carry, overflow);
    end
    step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_return_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({busy, done, carry, overflow} !== 4'b0000 || sum !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset: busy=%b done=%b sum=%h carry=%b ovf=%b, required 0 0 0000 0 0",
               busy, done, sum, carry, overflow);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: done/busy seen in %0d cycles after reset, required 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_back_to_back();
    test_arith();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
